// File: rtl/a2_arb_mux_n_1_pkg.sv
// Shared constants and helpers for the N:1 arbitrating output mux.
package a2_arb_mux_n_1_pkg;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   // Index width for n channels; never narrower than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/a2_arb_mux_n_1_if.sv
// Producer-side and consumer-side handshake bundle of the N:1 arbitrating mux.
interface a2_arb_mux_n_1_if #(
   parameter int N     = 4,
   parameter int WIDTH = 8
);
   import a2_arb_mux_n_1_pkg::*;

   localparam int SRC_W = clog2(N);

   logic [N-1:0]       in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [SRC_W-1:0]   out_src;
   logic               out_ready;

   // Environment side: producers and the downstream consumer.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_src
   );

   // Mux side.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_src
   );

endinterface

// File: rtl/a2_arb_mux_n_1_rr_arbiter.sv
// Round-robin / fixed-priority grant generator; owns the round-robin pointer.
module a2_arb_mux_n_1_rr_arbiter
   import a2_arb_mux_n_1_pkg::*;
#(
   parameter  int N     = 4,
   localparam int SRC_W = clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     i_req,
   input  logic             i_mode,
   input  logic             i_advance,
   output logic [N-1:0]     o_grant,
   output logic [SRC_W-1:0] o_grant_idx
);

   logic [SRC_W-1:0] r_ptr;
   logic [N-1:0]     w_grant;
   logic [SRC_W-1:0] w_idx;

   // Fixed priority is the same circular search anchored at channel 0.
   always_comb begin : p_grant
      int  cand;
      logic hit;
      cand    = 0;
      hit     = 1'b0;
      w_grant = '0;
      w_idx   = '0;
      for (int k = 0; k < N; k++) begin
         cand = (i_mode == MODE_FIXED) ? k : int'(r_ptr) + k;
         if (cand >= N) cand = cand - N;
         if (!hit && i_req[cand]) begin
            hit           = 1'b1;
            w_grant[cand] = 1'b1;
            w_idx         = SRC_W'(cand);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_advance && (i_mode == MODE_RR)) begin
         r_ptr <= (w_idx == SRC_W'(N - 1)) ? '0 : w_idx + 1'b1;
      end
   end

   assign o_grant     = w_grant;
   assign o_grant_idx = w_idx;

endmodule

// File: rtl/a2_arb_mux_n_1.sv
// N:1 arbitrating datapath mux: picks one valid producer, registers its word and index.
module a2_arb_mux_n_1
   import a2_arb_mux_n_1_pkg::*;
#(
   parameter  int N     = 4,
   parameter  int WIDTH = 8,
   localparam int SRC_W = clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           mode,
   a2_arb_mux_n_1_if.slave bus
);

   logic [N-1:0]     w_grant;
   logic [SRC_W-1:0] w_idx;
   logic [N-1:0]     w_ready;
   logic             w_can_load;
   logic             w_load;
   logic [WIDTH-1:0] w_chan [N];
   logic [WIDTH-1:0] w_sel;

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [SRC_W-1:0] r_src;

   a2_arb_mux_n_1_rr_arbiter #(.N(N)) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (bus.in_valid),
      .i_mode      (mode),
      .i_advance   (w_load),
      .o_grant     (w_grant),
      .o_grant_idx (w_idx)
   );

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_chan
         assign w_chan[gi] = bus.in_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   assign w_sel = w_chan[w_idx];

   // out_ready reaches in_ready combinationally so a drain and a load share one edge.
   assign w_can_load = ~r_valid | bus.out_ready;
   assign w_ready    = w_grant & {N{w_can_load & rst_n}};
   assign w_load     = |(bus.in_valid & w_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_src   <= '0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_data  <= w_sel;
         r_src   <= w_idx;
      end else if (bus.out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.out_valid = r_valid;
   assign bus.out_data  = r_data;
   assign bus.out_src   = r_src;

endmodule

// File: tb/tb_a2_arb_mux_n_1.sv
// Directed scenarios on a 4x8 instance plus a randomised scoreboard run on a 3x16 instance.
module tb_a2_arb_mux_n_1;
   import a2_arb_mux_n_1_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic mode4, mode3;
   int   checks = 0;
   int   errors = 0;

   a2_arb_mux_n_1_if #(.N(4), .WIDTH(8))  b4 ();
   a2_arb_mux_n_1_if #(.N(3), .WIDTH(16)) b3 ();

   a2_arb_mux_n_1 #(.N(4), .WIDTH(8)) u4 (
      .clk(clk), .rst_n(rst_n), .mode(mode4), .bus(b4.slave)
   );
   a2_arb_mux_n_1 #(.N(3), .WIDTH(16)) u3 (
      .clk(clk), .rst_n(rst_n), .mode(mode3), .bus(b3.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset;
      rst_n = 1'b1; mode4 = MODE_RR; mode3 = MODE_RR;
      b4.in_valid = '0; b4.in_data = {8'h44, 8'h33, 8'h22, 8'h11}; b4.out_ready = 1'b0;
      b3.in_valid = '0; b3.in_data = '0; b3.out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1 b4.in_valid = 4'hF;
      #1;
      checks++;
      if ({b4.out_valid, b4.out_src, b4.out_data} !== 11'h0 || b4.in_ready !== 4'h0) begin
         errors++;
         $display("FAIL reset_init: got v=%b src=%0d data=%h rdy=%b, exp 0/0/00/0000",
                  b4.out_valid, b4.out_src, b4.out_data, b4.in_ready);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;
      checks++;
      if ({b4.out_valid, b4.out_src, b4.out_data} !== {1'b1, 2'd0, 8'h11}) begin
         errors++;
         $display("FAIL reset_preload: got v=%b src=%0d data=%h, exp 1/0/11",
                  b4.out_valid, b4.out_src, b4.out_data);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({b4.out_valid, b4.out_src, b4.out_data} !== 11'h0 || b4.in_ready !== 4'h0) begin
         errors++;
         $display("FAIL reset_midxfer: got v=%b src=%0d data=%h rdy=%b, exp 0/0/00/0000",
                  b4.out_valid, b4.out_src, b4.out_data, b4.in_ready);
      end
      @(negedge clk) rst_n = 1'b1;
      b4.in_valid = '0;
   endtask

   task automatic test_rr_all;
      logic [1:0] es;
      logic [7:0] ed;
      b4.out_ready = 1'b1; mode4 = MODE_RR; b4.in_valid = 4'hF;
      #1;
      checks++;
      if (b4.in_ready !== 4'b0001) begin
         errors++;
         $display("FAIL rr_first_ready: got %b exp 0001", b4.in_ready);
      end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk) #1;
         es = 2'(k % 4);
         ed = 8'h11 * (8'(es) + 8'd1);
         checks++;
         if ({b4.out_valid, b4.out_src, b4.out_data} !== {1'b1, es, ed}) begin
            errors++;
            $display("FAIL rr_seq[%0d]: got v=%b src=%0d data=%h, exp 1/%0d/%h",
                     k, b4.out_valid, b4.out_src, b4.out_data, es, ed);
         end
         checks++;
         if (b4.in_ready !== (4'b0001 << ((k + 1) % 4))) begin
            errors++;
            $display("FAIL rr_ready[%0d]: got %b exp %b", k, b4.in_ready, 4'b0001 << ((k + 1) % 4));
         end
      end
   endtask

   task automatic test_fixed;
      logic [1:0] exp_src [3];
      exp_src = '{2'd3, 2'd1, 2'd3};
      // pointer is 1 here; one grant of channel 2 moves it to 3
      b4.in_valid = 4'b0100;
      @(posedge clk) #1;
      checks++;
      if ({b4.out_src, b4.out_data} !== {2'd2, 8'h33}) begin
         errors++;
         $display("FAIL fixed_setup: got src=%0d data=%h exp 2/33", b4.out_src, b4.out_data);
      end
      mode4 = MODE_FIXED; b4.in_valid = 4'b1010;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (b4.in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL fixed_ready[%0d]: got %b exp 0010", k, b4.in_ready);
         end
         @(posedge clk) #1;
         checks++;
         if ({b4.out_valid, b4.out_src, b4.out_data} !== {1'b1, 2'd1, 8'h22}) begin
            errors++;
            $display("FAIL fixed_out[%0d]: got v=%b src=%0d data=%h exp 1/1/22",
                     k, b4.out_valid, b4.out_src, b4.out_data);
         end
      end
      mode4 = MODE_RR;
      #1;
      checks++;
      if (b4.in_ready !== 4'b1000) begin
         errors++;
         $display("FAIL mode_switch_ready: got %b exp 1000", b4.in_ready);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk) #1;
         checks++;
         if (b4.out_src !== exp_src[k]) begin
            errors++;
            $display("FAIL rr_after_fixed[%0d]: got src=%0d exp %0d", k, b4.out_src, exp_src[k]);
         end
      end
   endtask

   task automatic test_backpressure;
      int n33;
      n33 = 0;
      b4.in_valid = 4'b0100;
      @(posedge clk) #1;
      b4.out_ready = 1'b0; b4.in_valid = 4'hF;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (b4.in_ready !== 4'h0) begin
            errors++;
            $display("FAIL stall_ready[%0d]: got %b exp 0000", k, b4.in_ready);
         end
         @(negedge clk);
         if (b4.out_valid && b4.out_ready && b4.out_data == 8'h33) n33++;
         @(posedge clk) #1;
         checks++;
         if ({b4.out_valid, b4.out_src, b4.out_data} !== {1'b1, 2'd2, 8'h33}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got v=%b src=%0d data=%h exp 1/2/33",
                     k, b4.out_valid, b4.out_src, b4.out_data);
         end
      end
      b4.out_ready = 1'b1;
      #1;
      checks++;
      if (b4.in_ready !== 4'b1000) begin
         errors++;
         $display("FAIL release_ready: got %b exp 1000", b4.in_ready);
      end
      @(negedge clk);
      if (b4.out_valid && b4.out_ready && b4.out_data == 8'h33) n33++;
      @(posedge clk) #1;
      checks++;
      if ({b4.out_valid, b4.out_src, b4.out_data} !== {1'b1, 2'd3, 8'h44}) begin
         errors++;
         $display("FAIL release_load: got v=%b src=%0d data=%h exp 1/3/44",
                  b4.out_valid, b4.out_src, b4.out_data);
      end
      b4.in_valid = '0;
      @(negedge clk);
      if (b4.out_valid && b4.out_ready && b4.out_data == 8'h33) n33++;
      checks++;
      if (n33 != 1) begin
         errors++;
         $display("FAIL stall_accept_once: got %0d accepts of 33 exp 1", n33);
      end
   endtask

   task automatic test_wrap;
      @(posedge clk) #1;
      b4.in_valid = 4'b0100;
      @(posedge clk) #1;
      b4.in_valid = 4'b0001;
      #1;
      checks++;
      if (b4.in_ready !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_ready: got %b exp 0001", b4.in_ready);
      end
      @(posedge clk) #1;
      checks++;
      if ({b4.out_valid, b4.out_src, b4.out_data} !== {1'b1, 2'd0, 8'h11}) begin
         errors++;
         $display("FAIL wrap_load: got v=%b src=%0d data=%h exp 1/0/11",
                  b4.out_valid, b4.out_src, b4.out_data);
      end
      b4.in_valid = '0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk) #1;
         checks++;
         if ({b4.out_valid, b4.out_src, b4.out_data} !== {1'b0, 2'd0, 8'h11} || b4.in_ready !== 4'h0) begin
            errors++;
            $display("FAIL idle_drain[%0d]: got v=%b src=%0d data=%h rdy=%b exp 0/0/11/0000",
                     k, b4.out_valid, b4.out_src, b4.out_data, b4.in_ready);
         end
      end
      b4.in_valid = 4'hF;
      #1;
      checks++;
      if (b4.in_ready !== 4'b0010) begin
         errors++;
         $display("FAIL wrap_ptr_kept: got %b exp 0010", b4.in_ready);
      end
      b4.in_valid = '0;
   endtask

   task automatic test_random;
      localparam int NC = 3;
      logic [17:0] q[$];
      logic [17:0] expw;
      int ptr, acc, win, base, c;
      bit m_valid, can;
      int wait_cnt [NC];
      logic [NC-1:0] exp_ready;
      ptr = 0; m_valid = 1'b0;
      for (int i = 0; i < NC; i++) wait_cnt[i] = 0;
      @(posedge clk) #1;
      b3.in_valid = '0; b3.out_ready = 1'b0; mode3 = MODE_RR;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         can  = !m_valid || b3.out_ready;
         base = (mode3 == MODE_RR) ? ptr : 0;
         win  = -1;
         for (int k = 0; k < NC; k++) begin
            c = (base + k) % NC;
            if (win < 0 && b3.in_valid[c]) win = c;
         end
         acc = (can && win >= 0) ? win : -1;
         exp_ready = (acc >= 0) ? NC'(1 << acc) : '0;
         checks++;
         if (b3.in_ready !== exp_ready || b3.out_valid !== m_valid) begin
            errors++;
            $display("FAIL rnd_hs[%0d]: got rdy=%b v=%b exp rdy=%b v=%b",
                     cyc, b3.in_ready, b3.out_valid, exp_ready, m_valid);
         end
         if (m_valid && b3.out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rnd_extra[%0d]: word drained with empty scoreboard", cyc);
            end else begin
               expw = q.pop_front();
               if ({b3.out_src, b3.out_data} !== expw) begin
                  errors++;
                  $display("FAIL rnd_word[%0d]: got src=%0d data=%h exp src=%0d data=%h",
                           cyc, b3.out_src, b3.out_data, expw[17:16], expw[15:0]);
               end
            end
         end
         if (acc >= 0) q.push_back({2'(acc), b3.in_data[acc*16 +: 16]});
         for (int i = 0; i < NC; i++) begin
            if (mode3 == MODE_RR && b3.in_valid[i] && i != acc) begin
               if (acc >= 0) wait_cnt[i]++;
               checks++;
               if (wait_cnt[i] > NC - 1) begin
                  errors++;
                  $display("FAIL rnd_starve[%0d]: ch%0d waited %0d transfers", cyc, i, wait_cnt[i]);
               end
            end else begin
               wait_cnt[i] = 0;
            end
         end
         if (acc >= 0) m_valid = 1'b1;
         else if (b3.out_ready) m_valid = 1'b0;
         if (acc >= 0 && mode3 == MODE_RR) ptr = (acc + 1) % NC;
         @(posedge clk) #1;
         for (int i = 0; i < NC; i++) begin
            if (i == acc || !b3.in_valid[i]) begin
               b3.in_valid[i] = (cyc < 1900) && ($urandom_range(0, 99) < 60);
               b3.in_data[i*16 +: 16] = 16'($urandom);
            end
         end
         b3.out_ready = (cyc >= 1900) || ($urandom_range(0, 99) < 70);
         mode3 = (cyc >= 1200 && cyc < 1800) ? 1'($urandom_range(0, 1)) : MODE_RR;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL rnd_lost: %0d accepted words never emerged, exp 0", q.size());
      end
   endtask

   initial begin
      test_reset();
      test_rr_all();
      test_fixed();
      test_backpressure();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
